eth_rx_parser: RTL and testbench

//  Parametrised, streaming successor of the fixed 4-word RX FSM: parses a variable-length

---
 rtl/eth_pkg.sv | 33 +++
 rtl/eth_rx_stats.sv | 23 ++
 rtl/eth_rx_parser.sv | 199 +++++++++++++++++++
 tb/tb_eth_rx_parser.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, address tables, FSM state codes and error codes
// for the Ethernet RX frame parser.
package eth_pkg;

  localparam int DATA_WIDTH = 32;

  // Address tables; a parser instance uses the first NUM_PORTS entries of each.
  localparam int ADDR_TABLE_SIZE = 2;
  localparam logic [31:0] PORT_ADDR [ADDR_TABLE_SIZE] = '{32'h0000_ABCD, 32'h0000_EFEF};
  localparam logic [31:0] IP_ADDR   [ADDR_TABLE_SIZE] = '{32'h0000_0123, 32'h0000_4567};

  // Reference CRC word used by the original fixed-format frames.
  localparam logic [31:0] CRC_DATA = 32'hDEAD_BEEF;

  // Parser states kept as plain constants so older code that compares raw
  // state values keeps working.
  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE    = 2'd0;
  localparam state_e ST_SRC     = 2'd1;
  localparam state_e ST_PAYLOAD = 2'd2;
  localparam state_e ST_DROP    = 2'd3;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    BAD_DEST  = 3'd1,
    BAD_SRC   = 3'd2,
    RUNT      = 3'd3,
    OVERSIZE  = 3'd4,
    SOP_ABORT = 3'd5,
    OVERFLOW  = 3'd6
  } err_e;

endpackage

// File: rtl/eth_rx_stats.sv
// eth_rx_stats: pair of 16-bit saturating event counters for delivered and
// dropped frames. Only instantiated when ETH_RX_STATS_EN is defined.
module eth_rx_stats (
  input  logic        clk,
  input  logic        rstn,
  input  logic        good_inc,
  input  logic        drop_inc,
  output logic [15:0] stat_good,
  output logic [15:0] stat_drop
);

  // Count events, holding at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_good <= '0;
      stat_drop <= '0;
    end else begin
      if (good_inc && (stat_good != 16'hFFFF)) stat_good <= stat_good + 16'd1;
      if (drop_inc && (stat_drop != 16'hFFFF)) stat_drop <= stat_drop + 16'd1;
    end
  end

endmodule

// File: rtl/eth_rx_parser.sv
// eth_rx_parser: streaming RX frame parser (dest, src, 1..MAX payload words, CRC).
// Validates addresses, drops malformed frames with a one-cycle error code, and
// presents each good frame through a valid/ready holding register.
// Build macro: ETH_RX_STATS_EN enables the stat_good/stat_drop counters;
// without it both ports are tied to zero.
module eth_rx_parser
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH        = eth_pkg::DATA_WIDTH,
  parameter int MAX_PAYLOAD_WORDS = 4,
  parameter int NUM_PORTS         = 2,
  localparam int LEN_W  = $clog2(MAX_PAYLOAD_WORDS + 1),
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  in_valid,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic                                  insop,
  input  logic                                  ineop,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_dest,
  output logic [DATA_WIDTH-1:0]                 out_src,
  output logic [MAX_PAYLOAD_WORDS*DATA_WIDTH-1:0] out_payload,
  output logic [LEN_W-1:0]                      out_len,
  output logic [DATA_WIDTH-1:0]                 out_crc,
  output logic [PORT_W-1:0]                     out_port,
  output logic                                  err_valid,
  output logic [2:0]                            err_code,
  output logic [15:0]                           stat_good,
  output logic [15:0]                           stat_drop
);

  state_e                                 state_q, state_d;
  logic [DATA_WIDTH-1:0]                  dest_q, src_q;
  logic [PORT_W-1:0]                      port_q;
  logic [LEN_W-1:0]                       count_q;
  logic [MAX_PAYLOAD_WORDS*DATA_WIDTH-1:0] pay_q;

  logic              dest_hit, src_hit;
  logic [PORT_W-1:0] port_hit;
  err_e              err_d;
  logic              err_hit;
  logic              latch_dest, latch_src, store_pay, complete, load_hold;

  // Look the current word up in both address tables; first matching port wins.
  always_comb begin
    dest_hit = 1'b0;
    src_hit  = 1'b0;
    port_hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!dest_hit && (in_data == DATA_WIDTH'(PORT_ADDR[i]))) begin
        dest_hit = 1'b1;
        port_hit = PORT_W'(i);
      end
      if (in_data == DATA_WIDTH'(IP_ADDR[i])) src_hit = 1'b1;
    end
  end

  // Next-state and per-word decisions. An sop word always restarts parsing as a
  // dest word; if it also aborts a live frame, SOP_ABORT is the error reported.
  always_comb begin
    state_d    = state_q;
    err_d      = NONE;
    latch_dest = 1'b0;
    latch_src  = 1'b0;
    store_pay  = 1'b0;
    complete   = 1'b0;
    if (in_valid) begin
      if (insop) begin
        if ((state_q == ST_SRC) || (state_q == ST_PAYLOAD)) err_d = SOP_ABORT;
        if (ineop) begin
          if (err_d == NONE) err_d = RUNT;
          state_d = ST_IDLE;
        end else if (!dest_hit) begin
          if (err_d == NONE) err_d = BAD_DEST;
          state_d = ST_DROP;
        end else begin
          latch_dest = 1'b1;
          state_d    = ST_SRC;
        end
      end else begin
        case (state_q)
          ST_SRC: begin
            if (ineop) begin
              err_d   = RUNT;
              state_d = ST_IDLE;
            end else if (!src_hit) begin
              err_d   = BAD_SRC;
              state_d = ST_DROP;
            end else begin
              latch_src = 1'b1;
              state_d   = ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (ineop) begin
              if (count_q == '0) err_d = RUNT;
              else               complete = 1'b1;
              state_d = ST_IDLE;
            end else if (count_q == LEN_W'(MAX_PAYLOAD_WORDS)) begin
              err_d   = OVERSIZE;
              state_d = ST_DROP;
            end else begin
              store_pay = 1'b1;
            end
          end
          ST_DROP: begin
            if (ineop) state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
    if (complete && out_valid && !out_ready) err_d = OVERFLOW;
  end

  assign load_hold = complete && !(out_valid && !out_ready);
  assign err_hit   = (err_d != NONE);

  // Parser state and the working copy of the frame being assembled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      src_q   <= '0;
      port_q  <= '0;
      count_q <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_dest) begin
        dest_q <= in_data;
        port_q <= port_hit;
      end
      if (latch_src) begin
        src_q   <= in_data;
        count_q <= '0;
        pay_q   <= '0;
      end
      if (store_pay) begin
        for (int i = 0; i < MAX_PAYLOAD_WORDS; i++)
          if (count_q == LEN_W'(i)) pay_q[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Holding register toward the FIFO writer: loads on completion unless a
  // stalled frame is still waiting, clears out_valid on handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_dest    <= '0;
      out_src     <= '0;
      out_payload <= '0;
      out_len     <= '0;
      out_crc     <= '0;
      out_port    <= '0;
    end else if (load_hold) begin
      out_valid   <= 1'b1;
      out_dest    <= dest_q;
      out_src     <= src_q;
      out_payload <= pay_q;
      out_len     <= count_q;
      out_crc     <= in_data;
      out_port    <= port_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Registered one-cycle error pulse for each dropped frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_valid <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      err_valid <= err_hit;
      err_code  <= err_d;
    end
  end

`ifdef ETH_RX_STATS_EN
  eth_rx_stats u_stats (
    .clk       (clk),
    .rstn      (rstn),
    .good_inc  (load_hold),
    .drop_inc  (err_hit),
    .stat_good (stat_good),
    .stat_drop (stat_drop)
  );
`else
  assign stat_good = '0;
  assign stat_drop = '0;
`endif

endmodule

// File: tb/tb_eth_rx_parser.sv
// tb_eth_rx_parser: directed and randomized bench for eth_rx_parser with a
// queue-based frame model compared against the DUT every cycle.
module tb_eth_rx_parser;

  localparam int DW   = 32;
  localparam int MAXP = 4;
  localparam int NP   = 2;
  localparam logic [31:0] TB_PORTS [2] = '{32'h0000_ABCD, 32'h0000_EFEF};
  localparam logic [31:0] TB_IPS   [2] = '{32'h0000_0123, 32'h0000_4567};
  localparam logic [31:0] TB_CRC = 32'hC0DE_CAFE;
`ifdef ETH_RX_STATS_EN
  localparam logic [15:0] STAT_ONE = 16'd1;
`else
  localparam logic [15:0] STAT_ONE = 16'd0;
`endif

  logic           clk, rstn, in_valid, insop, ineop, out_ready;
  logic [DW-1:0]  in_data;
  logic           out_valid, err_valid;
  logic [DW-1:0]  out_dest, out_src, out_crc;
  logic [MAXP*DW-1:0] out_payload;
  logic [2:0]     out_len, err_code;
  logic           out_port;
  logic [15:0]    stat_good, stat_drop;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  bit rnd_ready = 0;

  // Model state: the frame seen so far and the expected registered outputs.
  logic [31:0]  cur[$];
  bit           dropping;
  bit           m_ov, m_ev;
  logic [31:0]  m_dest, m_src, m_crc;
  logic [127:0] m_pay;
  logic [2:0]   m_len, m_ec;
  logic         m_port;
  logic [15:0]  m_good, m_drop;

  eth_rx_parser #(.DATA_WIDTH(DW), .MAX_PAYLOAD_WORDS(MAXP), .NUM_PORTS(NP)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .insop(insop), .ineop(ineop), .out_valid(out_valid), .out_ready(out_ready),
    .out_dest(out_dest), .out_src(out_src), .out_payload(out_payload),
    .out_len(out_len), .out_crc(out_crc), .out_port(out_port),
    .err_valid(err_valid), .err_code(err_code),
    .stat_good(stat_good), .stat_drop(stat_drop)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic s, input logic e);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    insop    = s;
    ineop    = e;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input logic [31:0] d, input logic [31:0] s, input int npay, input logic [31:0] base);
    applyStimulus(1'b1, d, 1'b1, 1'b0);
    applyStimulus(1'b1, s, 1'b0, 1'b0);
    for (int i = 0; i < npay; i++) applyStimulus(1'b1, base * 32'(i + 1), 1'b0, 1'b0);
    applyStimulus(1'b1, TB_CRC, 1'b0, 1'b1);
  endtask

  function automatic int portIdx(input logic [31:0] d);
    for (int i = 0; i < NP; i++) if (d == TB_PORTS[i]) return i;
    return -1;
  endfunction

  function automatic bit isIp(input logic [31:0] d);
    for (int i = 0; i < NP; i++) if (d == TB_IPS[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Frame-level reference: classify each consumed word by its position in the
  // current frame and decide drop reason or delivery from that.
  task automatic modelStep();
    logic [2:0]   err;
    bit           load;
    logic [31:0]  f_dest, f_src, f_crc;
    logic [127:0] f_pay;
    logic [2:0]   f_len;
    int           n;
    if (!rstn) begin
      m_ov = 0; m_ev = 0; m_dest = '0; m_src = '0; m_crc = '0; m_pay = '0;
      m_len = '0; m_ec = '0; m_port = 1'b0; m_good = '0; m_drop = '0;
      cur.delete();
      dropping = 0;
      return;
    end
    err = 3'd0; load = 0; f_dest = '0; f_src = '0; f_crc = '0; f_pay = '0; f_len = '0;
    if (in_valid) begin
      if (insop) begin
        if (cur.size() > 0 && !dropping) err = 3'd5;
        cur.delete();
        dropping = 0;
        cur.push_back(in_data);
        if (ineop) begin
          if (err == 3'd0) err = 3'd3;
          cur.delete();
        end else if (portIdx(in_data) < 0) begin
          if (err == 3'd0) err = 3'd1;
          dropping = 1;
        end
      end else if (dropping) begin
        if (ineop) begin
          dropping = 0;
          cur.delete();
        end
      end else if (cur.size() > 0) begin
        cur.push_back(in_data);
        n = cur.size();
        if (ineop) begin
          if (n <= 3) err = 3'd3;
          else begin
            load   = 1;
            f_dest = cur[0];
            f_src  = cur[1];
            f_crc  = cur[n-1];
            f_len  = 3'(n - 3);
            for (int i = 0; i < n - 3; i++) f_pay[i*32 +: 32] = cur[2+i];
          end
          cur.delete();
        end else if (n == 2 && !isIp(in_data)) begin
          err = 3'd2;
          dropping = 1;
        end else if (n - 2 > MAXP) begin
          err = 3'd4;
          dropping = 1;
        end
      end
    end
    if (load) begin
      if (m_ov && !out_ready) err = 3'd6;
      else begin
        m_ov = 1; m_dest = f_dest; m_src = f_src; m_crc = f_crc; m_pay = f_pay;
        m_len = f_len; m_port = 1'(portIdx(f_dest));
`ifdef ETH_RX_STATS_EN
        if (m_good != 16'hFFFF) m_good = m_good + 16'd1;
`endif
      end
    end else if (m_ov && out_ready) m_ov = 0;
    m_ev = (err != 3'd0);
    m_ec = err;
`ifdef ETH_RX_STATS_EN
    if (m_ev && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Cycle-by-cycle comparison of registered outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checkOutput("cyc_out_valid", 128'(out_valid), 128'(m_ov));
        checkOutput("cyc_err_valid", 128'(err_valid), 128'(m_ev));
        checkOutput("cyc_stat_good", 128'(stat_good), 128'(m_good));
        checkOutput("cyc_stat_drop", 128'(stat_drop), 128'(m_drop));
        if (m_ev) checkOutput("cyc_err_code", 128'(err_code), 128'(m_ec));
        if (m_ov) begin
          checkOutput("cyc_out_dest", 128'(out_dest), 128'(m_dest));
          checkOutput("cyc_out_src", 128'(out_src), 128'(m_src));
          checkOutput("cyc_out_payload", out_payload, m_pay);
          checkOutput("cyc_out_len", 128'(out_len), 128'(m_len));
          checkOutput("cyc_out_crc", 128'(out_crc), 128'(m_crc));
          checkOutput("cyc_out_port", 128'(out_port), 128'(m_port));
        end
      end
    end
  end

  task automatic sendWord(input logic [31:0] d, input logic s, input logic e);
    while ($urandom_range(0, 3) == 0)
      applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    applyStimulus(1'b1, d, s, e);
  endtask

  task automatic randomFrame();
    int kind, npay, cut;
    logic [31:0] w[$];
    logic [31:0] d, s;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      sendWord($urandom, 1'b0, 1'($urandom_range(0, 1)));
      return;
    end
    if (kind == 1) begin
      sendWord(TB_PORTS[$urandom_range(0, 1)], 1'b1, 1'b1);
      return;
    end
    d = ($urandom_range(0, 7) == 0) ? $urandom : TB_PORTS[$urandom_range(0, 1)];
    s = ($urandom_range(0, 7) == 0) ? $urandom : TB_IPS[$urandom_range(0, 1)];
    npay = $urandom_range(0, 6);
    w.push_back(d);
    w.push_back(s);
    for (int i = 0; i < npay; i++) w.push_back($urandom);
    w.push_back($urandom);
    cut = (kind == 2) ? $urandom_range(1, w.size() - 1) : w.size();
    for (int i = 0; i < cut; i++) sendWord(w[i], (i == 0), (i == w.size() - 1));
  endtask

  initial begin
    rstn = 0; in_valid = 0; in_data = '0; insop = 0; ineop = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_err_valid", 128'(err_valid), 128'(0));
    checkOutput("reset_out_payload", out_payload, 128'(0));
    rstn = 1;

    // 1: good frame, held with out_ready low, then handshake
    sendFrame(TB_PORTS[0], TB_IPS[0], 2, 32'h11);
    idle();
    checkOutput("t1_out_valid", 128'(out_valid), 128'(1));
    checkOutput("t1_out_len", 128'(out_len), 128'(2));
    checkOutput("t1_out_port", 128'(out_port), 128'(0));
    checkOutput("t1_out_dest", 128'(out_dest), 128'h0000_ABCD);
    checkOutput("t1_payload_lo", 128'(out_payload[63:0]), 128'h0000_0022_0000_0011);
    checkOutput("t1_payload_hi", 128'(out_payload[127:64]), 128'(0));
    checkOutput("t1_stat_good", 128'(stat_good), 128'(STAT_ONE));
    out_ready = 1;
    idle();
    checkOutput("t1_handshake", 128'(out_valid), 128'(0));
    out_ready = 0;

    // 2: bad destination
    applyStimulus(1'b1, 32'h1111, 1'b1, 1'b0);
    idle();
    checkOutput("t2_err_valid", 128'(err_valid), 128'(1));
    checkOutput("t2_err_code", 128'(err_code), 128'(1));
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b1);
    idle();
    checkOutput("t2_no_err", 128'(err_valid), 128'(0));
    checkOutput("t2_no_valid", 128'(out_valid), 128'(0));

    // 3: oversize then recovery
    applyStimulus(1'b1, TB_PORTS[0], 1'b1, 1'b0);
    applyStimulus(1'b1, TB_IPS[0], 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    idle();
    checkOutput("t3_err_code", 128'(err_code), 128'(4));
    applyStimulus(1'b1, 32'h9, 1'b0, 1'b1);
    sendFrame(TB_PORTS[1], TB_IPS[1], 4, 32'h3);
    idle();
    checkOutput("t3_recover_valid", 128'(out_valid), 128'(1));
    checkOutput("t3_recover_len", 128'(out_len), 128'(4));
    out_ready = 1;
    idle();
    out_ready = 0;

    // 4: overflow while a frame is held
    sendFrame(TB_PORTS[0], TB_IPS[0], 1, 32'hAA);
    idle();
    sendFrame(TB_PORTS[1], TB_IPS[1], 2, 32'hBB);
    idle();
    checkOutput("t4_err_code", 128'(err_code), 128'(6));
    checkOutput("t4_held_dest", 128'(out_dest), 128'h0000_ABCD);
    checkOutput("t4_held_payload", out_payload, 128'h0000_00AA);
    out_ready = 1;
    idle();
    checkOutput("t4_handshake", 128'(out_valid), 128'(0));

    // 5: sop abort with gaps in the restarted frame
    applyStimulus(1'b1, TB_PORTS[0], 1'b1, 1'b0);
    applyStimulus(1'b1, TB_IPS[0], 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, TB_PORTS[1], 1'b1, 1'b0);
    idle();
    checkOutput("t5_err_code", 128'(err_code), 128'(5));
    applyStimulus(1'b1, TB_IPS[1], 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hFFFF, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hFFFF, 1'b1, 1'b1);
    applyStimulus(1'b1, TB_CRC, 1'b0, 1'b1);
    idle();
    checkOutput("t5_out_port", 128'(out_port), 128'(1));
    checkOutput("t5_out_src", 128'(out_src), 128'h0000_4567);
    checkOutput("t5_out_len", 128'(out_len), 128'(1));
    idle();

    // 6: reset mid-payload with a frame held
    out_ready = 0;
    sendFrame(TB_PORTS[0], TB_IPS[0], 1, 32'h5);
    applyStimulus(1'b1, TB_PORTS[0], 1'b1, 1'b0);
    applyStimulus(1'b1, TB_IPS[0], 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
    rstn = 0;
    idle();
    checkOutput("t6_rst_valid", 128'(out_valid), 128'(0));
    checkOutput("t6_rst_dest", 128'(out_dest), 128'(0));
    checkOutput("t6_rst_err", 128'(err_valid), 128'(0));
    checkOutput("t6_rst_stat", 128'(stat_good), 128'(0));
    rstn = 1;
    sendFrame(TB_PORTS[1], TB_IPS[1], 2, 32'h7);
    idle();
    checkOutput("t6_out_valid", 128'(out_valid), 128'(1));
    checkOutput("t6_out_port", 128'(out_port), 128'(1));
    out_ready = 1;
    idle();

    // Randomized traffic with random back-pressure
    rnd_ready = 1;
    for (int f = 0; f < 400; f++) randomFrame();
    rnd_ready = 0;
    out_ready = 1;
    repeat (5) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
